// File: rtl/keypad_pkg.sv
// Shared constants and the key decode table for the hex keypad entry block.
package keypad_pkg;

    localparam int         DIGIT_W   = 4;
    localparam logic [3:0] COL_RESET = 4'b1110;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CANDIDATE = 2'd1,
        PRESSED   = 2'd2
    } db_state_t;

    // Physical layout: 1 2 3 A / 4 5 6 B / 7 8 9 C / 0 F E D
    function automatic logic [DIGIT_W-1:0] keymap(input logic [1:0] r, input logic [1:0] c);
        logic [DIGIT_W-1:0] k;
        case ({r, c})
            4'h0: k = 4'h1;
            4'h1: k = 4'h2;
            4'h2: k = 4'h3;
            4'h3: k = 4'hA;
            4'h4: k = 4'h4;
            4'h5: k = 4'h5;
            4'h6: k = 4'h6;
            4'h7: k = 4'hB;
            4'h8: k = 4'h7;
            4'h9: k = 4'h8;
            4'hA: k = 4'h9;
            4'hB: k = 4'hC;
            4'hC: k = 4'h0;
            4'hD: k = 4'hF;
            4'hE: k = 4'hE;
            default: k = 4'hD;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/key_scan_tick.sv
// Free-running divider producing a one-cycle clock enable every SCAN_DIV cycles.
module key_scan_tick #(
    parameter int SCAN_DIV = 50000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int            CW   = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_cnt <= '0;
        else if (r_cnt == LAST)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + CW'(1);
    end

    assign tick = (r_cnt == LAST);

endmodule

// File: rtl/keypad_hex_entry.sv
// 4x4 hex keypad scanner: column drive, full-scan decode with anti-ghosting,
// press/release debounce and a 4-digit shift-in entry register.
module keypad_hex_entry #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  row,
    input  logic        clear,
    output logic [3:0]  col,
    output logic [15:0] value,
    output logic [3:0]  key_code,
    output logic        key_strobe,
    output logic        key_held
);
    import keypad_pkg::*;

    localparam int             DBW    = (DEBOUNCE_SCANS > 2) ? $clog2(DEBOUNCE_SCANS) : 1;
    localparam logic [DBW-1:0] DB_PRE = DBW'(DEBOUNCE_SCANS - 1);

    logic [3:0]         r_row_meta, r_row_sync;
    logic               w_tick;
    logic [3:0]         r_col;
    logic [1:0]         r_col_idx;
    logic [1:0]         r_nkeys;
    logic [DIGIT_W-1:0] r_scan_code;
    db_state_t          r_state;
    logic [DIGIT_W-1:0] r_cand;
    logic [DBW-1:0]     r_cnt, r_rel;
    logic [15:0]        r_value;
    logic [DIGIT_W-1:0] r_key_code;
    logic               r_strobe, r_held;

    logic [3:0]         w_row_low;
    logic [2:0]         w_col_n, w_sum;
    logic [1:0]         w_col_row, w_nkeys_next;
    logic               w_valid, w_scan_end, w_accept;
    logic [DIGIT_W-1:0] w_code;

    key_scan_tick #(.SCAN_DIV(SCAN_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (w_tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_row_meta <= 4'hF;
            r_row_sync <= 4'hF;
        end else begin
            r_row_meta <= row;
            r_row_sync <= r_row_meta;
        end
    end

    // Key count per scan saturates at 2: anything beyond one key is just "invalid".
    always_comb begin
        w_row_low = ~r_row_sync;
        w_col_n   = 3'(w_row_low[0]) + 3'(w_row_low[1]) + 3'(w_row_low[2]) + 3'(w_row_low[3]);
        w_col_row = 2'd0;
        for (int r = 3; r >= 0; r--)
            if (w_row_low[r]) w_col_row = 2'(r);
        w_sum        = {1'b0, r_nkeys} + w_col_n;
        w_nkeys_next = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
        w_valid      = (w_sum == 3'd1);
        w_code       = (r_nkeys == 2'd1) ? r_scan_code : keymap(w_col_row, r_col_idx);
        w_scan_end   = w_tick && (r_col_idx == 2'd3);
        w_accept     = w_scan_end && (r_state == CANDIDATE) && w_valid &&
                       (w_code == r_cand) && (r_cnt == DB_PRE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_col       <= COL_RESET;
            r_col_idx   <= 2'd0;
            r_nkeys     <= 2'd0;
            r_scan_code <= '0;
        end else if (w_tick) begin
            r_col     <= {r_col[2:0], r_col[3]};
            r_col_idx <= r_col_idx + 2'd1;
            if (r_col_idx == 2'd3) begin
                r_nkeys     <= 2'd0;
                r_scan_code <= '0;
            end else begin
                r_nkeys     <= w_nkeys_next;
                r_scan_code <= w_code;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cand     <= '0;
            r_cnt      <= '0;
            r_rel      <= '0;
            r_value    <= '0;
            r_key_code <= '0;
            r_strobe   <= 1'b0;
            r_held     <= 1'b0;
        end else begin
            r_strobe <= w_accept;
            if (w_accept)
                r_key_code <= r_cand;
            // clear beats a same-cycle accept for value only
            if (clear)
                r_value <= '0;
            else if (w_accept)
                r_value <= {r_value[11:0], r_cand};

            if (w_scan_end) begin
                case (r_state)
                    IDLE: begin
                        if (w_valid) begin
                            r_state <= CANDIDATE;
                            r_cand  <= w_code;
                            r_cnt   <= DBW'(1);
                        end
                    end
                    CANDIDATE: begin
                        if (w_accept) begin
                            r_state <= PRESSED;
                            r_cnt   <= '0;
                            r_rel   <= '0;
                            r_held  <= 1'b1;
                        end else if (w_valid && w_code == r_cand) begin
                            r_cnt <= r_cnt + DBW'(1);
                        end else begin
                            r_state <= IDLE;
                            r_cnt   <= '0;
                        end
                    end
                    PRESSED: begin
                        if (w_valid) begin
                            r_rel <= '0;
                        end else if (r_rel == DB_PRE) begin
                            r_state <= IDLE;
                            r_rel   <= '0;
                            r_held  <= 1'b0;
                        end else begin
                            r_rel <= r_rel + DBW'(1);
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign col        = r_col;
    assign value      = r_value;
    assign key_code   = r_key_code;
    assign key_strobe = r_strobe;
    assign key_held   = r_held;

endmodule

// File: tb/tb_keypad_hex_entry.sv
// Bench for keypad_hex_entry: keypad matrix model, per-scan reference model, directed + random presses.
module tb_keypad_hex_entry;

    localparam int SD = 4;
    localparam int DB = 3;
    localparam int SCAN = 4 * SD;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  row;
    logic        clear = 1'b0;
    logic [3:0]  col;
    logic [15:0] value;
    logic [3:0]  key_code;
    logic        key_strobe;
    logic        key_held;

    logic [15:0] pressed = '0;
    int errors = 0;
    int checks = 0;
    int n_strobe = 0;
    bit started = 0;

    keypad_hex_entry #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
        .clk(clk), .reset(reset), .row(row), .clear(clear), .col(col),
        .value(value), .key_code(key_code), .key_strobe(key_strobe), .key_held(key_held)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] km(input int idx);
        case (idx)
            0: return 4'h1;  1: return 4'h2;  2: return 4'h3;  3: return 4'hA;
            4: return 4'h4;  5: return 4'h5;  6: return 4'h6;  7: return 4'hB;
            8: return 4'h7;  9: return 4'h8; 10: return 4'h9; 11: return 4'hC;
           12: return 4'h0; 13: return 4'hF; 14: return 4'hE; default: return 4'hD;
        endcase
    endfunction

    function automatic logic [15:0] key_mask(input logic [3:0] code);
        logic [15:0] m;
        m = '0;
        for (int i = 0; i < 16; i++)
            if (km(i) == code) m[i] = 1'b1;
        return m;
    endfunction

    // Keypad matrix: a pressed key shorts its row to the driven-low column.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
    end

    // Reference model: edge count since reset gives tick/column; one decision per full scan.
    int          m_n, m_c, m_nk, m_state, m_cnt, m_rel;
    logic [3:0]  m_s1, m_s2, m_samp, m_code, m_cand;
    logic [3:0]  m_scan [4];
    bit          m_acc;
    logic [3:0]  e_col, e_code;
    logic [15:0] e_value;
    logic        e_strobe, e_held;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_n = 0; m_s1 = 4'hF; m_s2 = 4'hF;
            for (int i = 0; i < 4; i++) m_scan[i] = 4'hF;
            m_state = 0; m_cand = 0; m_cnt = 0; m_rel = 0;
            e_col = 4'b1110; e_value = 0; e_code = 0; e_strobe = 0; e_held = 0;
        end else begin
            m_samp = m_s2; m_s2 = m_s1; m_s1 = row;
            m_acc = 0;
            if (m_n % SD == SD - 1) begin
                m_c = (m_n / SD) % 4;
                m_scan[m_c] = m_samp;
                if (m_c == 3) begin
                    m_nk = 0; m_code = 0;
                    for (int r = 0; r < 4; r++)
                        for (int c = 0; c < 4; c++)
                            if (!m_scan[c][r]) begin m_nk++; m_code = km(r*4+c); end
                    if (m_state == 0) begin
                        if (m_nk == 1) begin m_state = 1; m_cand = m_code; m_cnt = 1; end
                    end else if (m_state == 1) begin
                        if (m_nk == 1 && m_code == m_cand) begin
                            m_cnt++;
                            if (m_cnt == DB) begin m_state = 2; m_rel = 0; m_acc = 1; end
                        end else begin
                            m_state = 0; m_cnt = 0;
                        end
                    end else begin
                        if (m_nk == 1) m_rel = 0;
                        else begin m_rel++; if (m_rel == DB) m_state = 0; end
                    end
                end
            end
            e_strobe = m_acc;
            if (m_acc) e_code = m_cand;
            e_held = (m_state == 2);
            if (clear) e_value = 0;
            else if (m_acc) e_value = {e_value[11:0], m_cand};
            m_n++;
            e_col = 4'hF;
            e_col[(m_n / SD) % 4] = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            if (key_strobe) n_strobe++;
            checks++;
            if ({col, value, key_code, key_strobe, key_held} !== {e_col, e_value, e_code, e_strobe, e_held}) begin
                errors++;
                $display("FAIL model t=%0t dut col=%b val=%h code=%h stb=%b held=%b, want col=%b val=%h code=%h stb=%b held=%b",
                         $time, col, value, key_code, key_strobe, key_held,
                         e_col, e_value, e_code, e_strobe, e_held);
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic enter(input logic [3:0] code);
        pressed = key_mask(code); cyc(5 * SCAN);
        pressed = '0;             cyc(5 * SCAN);
    endtask

    int  s0;
    bit  found;
    logic [15:0] msk;

    initial begin
        started = 1;
        cyc(3);
        reset = 0;
        cyc(6);
        reset = 1; #1;
        chk("rst_col", 16'(col), 16'b1110);
        chk("rst_value", value, 16'h0000);
        chk("rst_stb_held", {14'd0, key_strobe, key_held}, 16'd0);
        cyc(2);
        reset = 0;
        cyc(3); chk("col_hold", 16'(col), 16'b1110);
        cyc(1); chk("col_1", 16'(col), 16'b1101);
        cyc(4); chk("col_2", 16'(col), 16'b1011);
        cyc(4); chk("col_3", 16'(col), 16'b0111);
        cyc(4); chk("col_wrap", 16'(col), 16'b1110);

        s0 = n_strobe;
        pressed = key_mask(4'h5); cyc(8 * SCAN);
        chk("k5_strobes", 16'(n_strobe - s0), 16'd1);
        chk("k5_code", 16'(key_code), 16'h5);
        chk("k5_value", value, 16'h0005);
        chk("k5_held", 16'(key_held), 16'd1);
        pressed = '0; cyc(SCAN);
        chk("k5_held_rel1", 16'(key_held), 16'd1);
        cyc(4 * SCAN);
        chk("k5_released", 16'(key_held), 16'd0);
        chk("k5_one_strobe", 16'(n_strobe - s0), 16'd1);

        clear = 1; cyc(1); clear = 0;
        s0 = n_strobe;
        enter(4'h1); chk("seq_1", value, 16'h0001);
        enter(4'h2); chk("seq_2", value, 16'h0012);
        enter(4'h3); chk("seq_3", value, 16'h0123);
        enter(4'hA); chk("seq_A", value, 16'h123A);
        enter(4'hF); chk("seq_F", value, 16'h23AF);
        chk("seq_strobes", 16'(n_strobe - s0), 16'd5);

        s0 = n_strobe;
        pressed = key_mask(4'h7); cyc(2 * SCAN);
        pressed = '0;             cyc(SCAN);
        pressed = key_mask(4'h7); cyc(2 * SCAN);
        pressed = '0;             cyc(5 * SCAN);
        chk("bounce_nostrobe", 16'(n_strobe - s0), 16'd0);
        chk("bounce_value", value, 16'h23AF);
        pressed = key_mask(4'h1) | key_mask(4'h2); cyc(6 * SCAN);
        pressed = '0; cyc(5 * SCAN);
        chk("ghost_nostrobe", 16'(n_strobe - s0), 16'd0);

        clear = 1; cyc(1); clear = 0;
        enter(4'hA); enter(4'hB);
        chk("pre_clear_value", value, 16'h00AB);
        pressed = key_mask(4'h9);
        found = 0;
        for (int i = 0; i < 20 * SCAN && !found; i++) begin
            if (m_state == 1 && m_cnt == DB - 1 && (m_n % SCAN) == SCAN - 1) found = 1;
            else cyc(1);
        end
        chk("clear_accept_seen", 16'(found), 16'd1);
        clear = 1; cyc(1); clear = 0;
        chk("clr_value", value, 16'h0000);
        chk("clr_code", 16'(key_code), 16'h9);
        chk("clr_strobe", 16'(key_strobe), 16'd1);
        pressed = '0; cyc(5 * SCAN);

        pressed = key_mask(4'hD); cyc(5 * SCAN);
        chk("d_held", 16'(key_held), 16'd1);
        s0 = n_strobe;
        reset = 1; cyc(2);
        chk("d_rst_held", 16'(key_held), 16'd0);
        chk("d_rst_value", value, 16'h0000);
        reset = 0;
        cyc(6 * SCAN);
        chk("d_one_strobe", 16'(n_strobe - s0), 16'd1);
        chk("d_code", 16'(key_code), 16'hD);
        chk("d_value", value, 16'h000D);
        pressed = '0; cyc(5 * SCAN);

        for (int it = 0; it < 150; it++) begin
            case ($urandom_range(0, 7))
                0:       msk = '0;
                1:       msk = 16'(1 << $urandom_range(0, 15)) | 16'(1 << $urandom_range(0, 15));
                default: msk = 16'(1 << $urandom_range(0, 15));
            endcase
            pressed = msk;
            for (int k = $urandom_range(8, 100); k > 0; k--) begin
                clear = ($urandom_range(0, 39) == 0);
                cyc(1);
            end
            clear = 0;
        end
        pressed = '0; cyc(5 * SCAN);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/keypad_hex_entry.md
Name: keypad_hex_entry

Overview:
- Input-side counterpart of the multiplexed hex display driver.
- Scans a 4x4 matrix hex keypad by driving one column low at a time and sampling the rows.
- Debounces each keypress and decodes it to a 4-bit hex digit.
- Shifts accepted digits into a 16-bit value that the display path can show and that downstream logic consumes.

Parameters:
- SCAN_DIV, 50000: clk cycles per column dwell (scan tick period); minimum 2.
- DEBOUNCE_SCANS, 4: consecutive identical full scans required to accept a press, and also to accept a release; minimum 2.

Ports:
- clk  in  1  system clock; all logic in this single domain.
- reset  in  1  asynchronous, active-high reset.
- row  in  4  keypad rows, active-low (external pull-ups); asynchronous to clk.
- clear  in  1  synchronous clear of value.
- col  out  4  keypad column drive, active-low; exactly one bit low at all times.
- value  out  16  accumulated entry; newest digit in [3:0].
- key_code  out  4  hex code of the last accepted key.
- key_strobe  out  1  one-cycle pulse per accepted key.
- key_held  out  1  high while an accepted key is still pressed.

Behaviour:
- Reset values: col=4'b1110, value=0, key_code=0, key_strobe=0, key_held=0, FSM=IDLE, all counters 0.
- row passes through a 2-flop synchronizer before any use.
- Tick generation:
  - Counter runs 0..SCAN_DIV-1; tick asserts when the counter is at SCAN_DIV-1.
  - No derived clocks; tick is a clock enable.
- Column sequencing:
  - On each tick the synchronized row is sampled for the current column, then col rotates 1110→1101→1011→0111→1110.
  - Column index c = position of the low bit.
- Full-scan result:
  - Evaluated on the tick that samples column 3.
  - Exactly one key (row r low, column c) across all four columns gives valid=1, code=KEYMAP[r][c].
  - Zero keys or two or more keys gives valid=0 (anti-ghosting).
- KEYMAP (row 0..3, columns 0..3): 1 2 3 A / 4 5 6 B / 7 8 9 C / 0 F E D.
- Debounce FSM, evaluated once per full scan:
  - IDLE: valid → CANDIDATE, cand=code, cnt=1.
  - CANDIDATE:
    - valid with code==cand → cnt+1.
    - When cnt reaches DEBOUNCE_SCANS → PRESSED and accept.
    - Invalid, or a different code → IDLE (a different code restarts from IDLE on the next scan).
  - PRESSED:
    - key_held=1.
    - Release count increments on each invalid scan and clears on any valid scan.
    - Reaching DEBOUNCE_SCANS → IDLE with key_held=0.
    - No auto-repeat; a different key while PRESSED is ignored until release.
- Accept action (the cycle after the scan-end tick):
  - key_strobe=1 for exactly one cycle.
  - key_code=cand.
  - value={value[11:0], cand}; the oldest digit is discarded (wrap by shifting).
- clear:
  - value=0 the next cycle.
  - If coincident with an accept, clear wins: value=0, but key_strobe still pulses and key_code still updates.
- Latency: a key stable from column sampling onward strobes after DEBOUNCE_SCANS full scans (4*SCAN_DIV*DEBOUNCE_SCANS cycles), +1 scan of phase uncertainty, +2 synchronizer cycles.
- Reset mid-operation returns to reset values immediately. A key held through reset deassertion must be re-debounced and yields exactly one strobe.

Decomposition:
- Package keypad_pkg:
  - KEYMAP constant/function (row, col → 4-bit code).
  - Debounce state enum {IDLE, CANDIDATE, PRESSED}.
  - COL_RESET=4'b1110.
  - DIGIT_W=4.
- Sub-module key_scan_tick: parameterized SCAN_DIV counter producing the one-cycle tick enable (clk, reset, tick).
- Top level holds the synchronizer, column rotation, scan accumulation, debounce FSM and shift register.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=3; keypad model pulls row[r] low when col[c] is low and key (r,c) is pressed):
- Reset asserted mid-count, then released → col=1110, value=0000, strobe/held=0; col then rotates every 4 cycles in order 1110,1101,1011,0111.
- Press '5' (r1,c1) for 8 scans, then release → exactly one key_strobe, key_code=5, value=0x0005, key_held high until 3 empty scans.
- Enter 1,2,3,A, each with a clean release, then 'F' → value 0x0001, 0x0012, 0x0123, 0x123A, then 0x23AF; five strobes total.
- Bounce: '7' pressed 2 scans, released 1, pressed 2, released → no strobe, value unchanged. Two keys '1'+'2' held 6 scans → no strobe.
- clear pulsed on the same cycle as the accept of '9' with value=0x00AB → value=0x0000, key_code=9, strobe=1.
- Reset pulsed while 'D' held in PRESSED, key kept held → outputs reset, then exactly one strobe with key_code=D after 3 scans; value=0x000D.
